baud_gen_frac: RTL
==================

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter DEF_BAUD, default 9600, meaning baud rate loaded at reset.
REQ-003 SHALL have parameter OVS, default 16, meaning oversample ticks per bit (power of 2, >=2).
REQ-004 SHALL have parameter INT_W, default 16, meaning width of the integer divisor.
REQ-005 SHALL have parameter FRAC_W, default 4, meaning width of the fractional divisor.
REQ-006 SHALL have port clk  in  1  system clock.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port en  in  1  count enable.
REQ-009 SHALL have port restart  in  1  synchronous phase-restart pulse (RX start-bit alignment).
REQ-010 SHALL have port div_load  in  1  single-cycle strobe to latch div_int/div_frac.
REQ-011 SHALL have port div_int  in  INT_W  integer part of the clocks-per-oversample-tick divisor.
REQ-012 SHALL have port div_frac  in  FRAC_W  fractional part, in units of 1/2^FRAC_W clock.
REQ-013 SHALL have port os_tick  out  1  oversample tick, one-cycle pulse.
REQ-014 SHALL have port bit_tick  out  1  bit tick, one-cycle pulse.
REQ-015 SHALL have port os_idx  out  $clog2(OVS)  oversample-tick index within the bit.
REQ-016 SHALL have port div_pend  out  1  accepted divisor waiting to take effect.
REQ-017 SHALL have port div_err  out  1  one-cycle pulse on a rejected load.

Function
REQ-018 SHALL hold an active divisor (act_int, act_frac) and a shadow divisor (sh_int, sh_frac).
REQ-019 SHALL run a period counter cnt, 0 to len-1, where len = act_int + c.
REQ-020 SHALL set c as follows: at each period start, {c, acc} = acc + act_frac, computed at FRAC_W+1 bits with acc FRAC_W bits wide.
REQ-021 SHALL register os_tick so it is high for exactly one clk in the cycle after cnt == len-1; cnt wraps to 0 on that same edge (the wrap).
REQ-022 SHALL increment os_idx modulo OVS on every os_tick edge.
REQ-023 SHALL assert bit_tick together with the os_tick whose edge wraps os_idx from OVS-1 to 0.
REQ-024 SHALL, with en=0, hold cnt, acc and os_idx, and assert neither tick; counting resumes from the held cnt.
REQ-025 SHALL, on a restart pulse, set cnt=0, acc=0 and os_idx=0, suppress any tick that edge, and apply a pending shadow immediately; restart has priority over a wrap.
REQ-026 SHALL, on div_load with div_int >= 2, copy the inputs to the shadow and set div_pend=1.
REQ-027 SHALL, on div_load with div_int < 2, pulse div_err for 1 cycle and leave shadow and div_pend unchanged.
REQ-028 SHALL keep the last accepted load when div_load repeats while div_pend=1.
REQ-029 SHALL copy the shadow to active at the first wrap strictly after the load cycle, or at the next edge if en=0, then clear div_pend.
REQ-030 SHALL, when a load coincides with a wrap, apply the load at the following wrap.
REQ-031 SHALL produce a long-run os_tick period equal to act_int + act_frac/2^FRAC_W clocks exactly, with no drift.

Reset
REQ-032 SHALL compute DEF_DIV = floor(CLK_HZ*2^FRAC_W/(DEF_BAUD*OVS)).
REQ-033 SHALL, while rst=1, set act_int = sh_int = DEF_DIV>>FRAC_W and act_frac = sh_frac = DEF_DIV mod 2^FRAC_W; with default parameters this gives 651 and 0.
REQ-034 SHALL, while rst=1, clear cnt, acc, os_idx, os_tick, bit_tick, div_pend and div_err.
REQ-035 SHALL, on rst asserted mid-period, immediately discard all in-flight state including a pending shadow.

Verification
REQ-036 SHALL cover: defaults, en=1 -> os_tick every 651 clks; bit_tick every 10416 clks.
REQ-037 SHALL cover: load int=4, frac=8 (FRAC_W=4), then restart -> os_tick spacing 4,5,4,5...; 32 ticks span 144 clks.
REQ-038 SHALL cover: OVS=16, int=4, frac=0 -> bit_tick on every 16th os_tick, os_idx=0 in the bit_tick cycle.
REQ-039 SHALL cover: load int=1 -> div_err one cycle, div_pend=0, tick spacing unchanged.
REQ-040 SHALL cover: load int=10 two cycles before a wrap of int=4 -> one more 4-clk period, then 10-clk periods; div_pend clears at that wrap.
REQ-041 SHALL cover: restart at cnt=2 of int=4 -> no tick, next os_tick 4 clks later with os_idx=1; rst mid-count -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: emits an oversample tick every
// div_int + div_frac/2^FRAC_W clocks on average (first-order fractional
// accumulator, no long-run drift) and a bit tick on every OVS-th oversample
// tick. A new divisor is staged in a shadow register and swapped in at a
// period boundary so the tick train never sees a truncated period.
module baud_gen_frac #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int DEF_BAUD = 9600,
    parameter int OVS      = 16,
    parameter int INT_W    = 16,
    parameter int FRAC_W   = 4,
    localparam int IDX_W   = (OVS > 1) ? $clog2(OVS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic              div_load,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic              bit_tick,
    output logic [IDX_W-1:0]  os_idx,
    output logic              div_pend,
    output logic              div_err
);

    // Reset divisor in units of 1/2^FRAC_W clock, evaluated in 64 bits so
    // CLK_HZ * 2^FRAC_W cannot overflow for realistic clock rates.
    localparam logic [63:0] DEF_DIV =
        (64'(CLK_HZ) << FRAC_W) / (64'(DEF_BAUD) * 64'(OVS));
    localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(DEF_DIV >> FRAC_W);
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_DIV[FRAC_W-1:0];
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OVS - 1);

    // Divisor load protocol: div_load is a single-cycle strobe with no
    // back-pressure. A strobe with div_int >= 2 is always accepted into the
    // shadow (a later accepted strobe overwrites an earlier pending one);
    // a strobe with div_int < 2 is dropped and answered with a one-cycle
    // div_err pulse. div_pend reports an accepted divisor not yet active.

    // Active and shadow divisor
    logic [INT_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [INT_W-1:0]  sh_int_q,   sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q,  sh_frac_d;
    logic              div_pend_q, div_pend_d;
    logic              div_err_q,  div_err_d;

    // Period counter, fractional phase and oversample index
    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              os_tick_q,  os_tick_d;
    logic              bit_tick_q, bit_tick_d;

    // Decode helpers
    logic [FRAC_W:0]   frac_sum;
    logic              carry;
    logic [INT_W:0]    len_m1;
    logic              at_end;
    logic              wrap;
    logic              load_ok;
    logic              load_bad;
    logic              apply;

    // Period length and wrap/apply decisions for the current cycle
    always_comb begin
        // The carry out of acc + act_frac decides whether this period is
        // one clock longer; the sum itself is committed at the wrap.
        frac_sum = {1'b0, acc_q} + {1'b0, act_frac_q};
        carry    = frac_sum[FRAC_W];
        len_m1   = {1'b0, act_int_q} + {{INT_W{1'b0}}, carry}
                   - {{INT_W{1'b0}}, 1'b1};
        // ">=" rather than "==" so a divisor shrunk while en=0 below the
        // held count still terminates at the next enabled edge.
        at_end   = ({1'b0, cnt_q} >= len_m1);
        // A restart pulse wins over a coincident wrap.
        wrap     = en && at_end && !restart;
        load_ok  = div_load && (div_int >= INT_W'(2));
        load_bad = div_load && (div_int <  INT_W'(2));
        // A divisor accepted this very cycle is never applied on the same
        // edge; it waits for the next qualifying edge.
        apply    = div_pend_q && !load_ok && (restart || !en || wrap);
    end

    // Next-state for the counter, fractional phase, index and ticks
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
            acc_d = '0;
            idx_d = '0;
        end else if (en) begin
            if (at_end) begin
                cnt_d      = '0;
                acc_d      = frac_sum[FRAC_W-1:0];
                os_tick_d  = 1'b1;
                bit_tick_d = (idx_q == LAST_IDX);
                idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + INT_W'(1);
            end
        end
    end

    // Next-state for the shadow/active divisor and status flags
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        div_pend_d = div_pend_q;
        div_err_d  = load_bad;
        if (load_ok) begin
            sh_int_d   = div_int;
            sh_frac_d  = div_frac;
            div_pend_d = 1'b1;
        end else if (apply) begin
            act_int_d  = sh_int_q;
            act_frac_d = sh_frac_q;
            div_pend_d = 1'b0;
        end
    end

    // Counter, phase, index and tick registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    // Divisor registers; reset discards any pending shadow value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_int_q  <= DEF_INT;
            act_frac_q <= DEF_FRAC;
            sh_int_q   <= DEF_INT;
            sh_frac_q  <= DEF_FRAC;
            div_pend_q <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            div_pend_q <= div_pend_d;
            div_err_q  <= div_err_d;
        end
    end

    assign os_tick  = os_tick_q;
    assign bit_tick = bit_tick_q;
    assign os_idx   = idx_q;
    assign div_pend = div_pend_q;
    assign div_err  = div_err_q;

endmodule
